// File: rtl/femto_pkg.sv
// femto_pkg: shared definitions for the Femto sequencer and its accumulator ALU.
// Holds the opcode constants, the sequencer state enum and a helper that gives
// the number of 4-bit nibbles needed to load one {op, imm} program word.
package femto_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_NOT  = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_STA  = 6;
  localparam int unsigned OP_DISP = 7;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  // One opcode nibble followed by SIZE/4 immediate nibbles.
  function automatic int unsigned nib_count(input int unsigned size);
    return 1 + size / 4;
  endfunction

endpackage

// File: rtl/femto_prog_mem.sv
// femto_prog_mem: program storage for the Femto sequencer.
// DEPTH x WIDTH array, synchronous write, asynchronous read, no reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  combinational read data
module femto_prog_mem #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/femto_sequencer.sv
// femto_sequencer: program loader and instruction issuer for the Femto ALU.
// LOAD mode assembles {op, imm} words from a nibble stream into program memory;
// RUN mode replays the program in a loop, one instruction per clock, and
// captures the ALU result into the display register on STA/DISP.
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst      synchronous active-high reset
//   i_run      1 = RUN mode, 0 = LOAD mode (level)
//   i_ld_en    nibble strobe, LOAD only
//   i_ld_nib   nibble data
//   i_alu_out  ALU combinational result
//   o_op       registered opcode to ALU
//   o_inp      registered operand to ALU
//   o_disp     registered display value
//   o_running  state is RUN
//   o_full     program memory is full
module femto_sequencer
  import femto_pkg::*;
#(
  parameter int unsigned OPSIZE = 3,
  parameter int unsigned SIZE   = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_ld_en,
  input  logic [3:0]        i_ld_nib,
  input  logic [SIZE-1:0]   i_alu_out,
  output logic [OPSIZE-1:0] o_op,
  output logic [SIZE-1:0]   o_inp,
  output logic [SIZE-1:0]   o_disp,
  output logic              o_running,
  output logic              o_full
);

  localparam int unsigned NIB = nib_count(SIZE);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(NIB + 1);
  localparam int unsigned WW  = OPSIZE + SIZE;

  state_t            r_state,   w_state_next;
  logic [AW-1:0]     r_pc,      w_pc_next;
  logic [AW:0]       r_len,     w_len_next;
  logic [CW-1:0]     r_nib_cnt, w_nib_cnt_next;
  logic [OPSIZE-1:0] r_asm_op,  w_asm_op_next;
  logic [SIZE-1:0]   r_imm,     w_imm_next;
  logic [OPSIZE-1:0] r_op,      w_op_next;
  logic [SIZE-1:0]   r_inp,     w_inp_next;
  logic [SIZE-1:0]   r_disp,    w_disp_next;

  logic          w_full;
  logic          w_last_nib;
  logic [AW:0]   w_pc_inc;
  logic          w_mem_we;
  logic [WW-1:0] w_mem_wdata;
  logic [WW-1:0] w_mem_rdata;

  assign w_full     = (r_len == (AW + 1)'(DEPTH));
  assign w_last_nib = (r_nib_cnt == CW'(NIB - 1));
  assign w_pc_inc   = {1'b0, r_pc} + (AW + 1)'(1);

  // Immediate slots are written by position so the final nibble can go
  // straight to memory on the edge it arrives.
  always_comb begin
    w_imm_next = r_imm;
    for (int unsigned k = 0; k < NIB - 1; k++) begin
      if (r_nib_cnt == CW'(k + 1)) begin
        w_imm_next[k*4 +: 4] = i_ld_nib;
      end
    end
  end

  assign w_mem_wdata = {r_asm_op, w_imm_next};

  // Display capture is independent of mode.
  always_comb begin
    w_disp_next = r_disp;
    if (r_op == OPSIZE'(OP_STA) || r_op == OPSIZE'(OP_DISP)) begin
      w_disp_next = i_alu_out;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_len_next     = r_len;
    w_nib_cnt_next = r_nib_cnt;
    w_asm_op_next  = r_asm_op;
    w_op_next      = r_op;
    w_inp_next     = r_inp;
    w_mem_we       = 1'b0;

    unique case (r_state)
      ST_LOAD: begin
        // The ALU treats some non-zero NOP operands as writes, so hold 0/0.
        w_op_next  = '0;
        w_inp_next = '0;
        if (i_run) begin
          // Transition wins over a coincident nibble; partial word dropped.
          w_state_next   = ST_RUN;
          w_pc_next      = '0;
          w_nib_cnt_next = '0;
        end else if (i_ld_en && !w_full) begin
          if (r_nib_cnt == '0) begin
            w_asm_op_next = i_ld_nib[OPSIZE-1:0];
          end
          if (w_last_nib) begin
            w_mem_we       = 1'b1;
            w_len_next     = r_len + (AW + 1)'(1);
            w_nib_cnt_next = '0;
          end else begin
            w_nib_cnt_next = r_nib_cnt + CW'(1);
          end
        end
      end
      ST_RUN: begin
        if (!i_run) begin
          w_state_next = ST_LOAD;
          w_op_next    = '0;
          w_inp_next   = '0;
          w_pc_next    = '0;
          w_len_next   = '0;
        end else if (r_len == '0) begin
          w_op_next  = '0;
          w_inp_next = '0;
          w_pc_next  = '0;
        end else begin
          w_op_next  = w_mem_rdata[WW-1:SIZE];
          w_inp_next = w_mem_rdata[SIZE-1:0];
          w_pc_next  = (w_pc_inc == r_len) ? '0 : w_pc_inc[AW-1:0];
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_LOAD;
      r_pc      <= '0;
      r_len     <= '0;
      r_nib_cnt <= '0;
      r_asm_op  <= '0;
      r_imm     <= '0;
      r_op      <= '0;
      r_inp     <= '0;
      r_disp    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_len     <= w_len_next;
      r_nib_cnt <= w_nib_cnt_next;
      r_asm_op  <= w_asm_op_next;
      if (r_state == ST_LOAD && !i_run && i_ld_en && !w_full) begin
        r_imm <= w_imm_next;
      end
      r_op      <= w_op_next;
      r_inp     <= w_inp_next;
      r_disp    <= w_disp_next;
    end
  end

  femto_prog_mem #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we & ~i_rst),
    .i_waddr (r_len[AW-1:0]),
    .i_wdata (w_mem_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_mem_rdata)
  );

  assign o_op      = r_op;
  assign o_inp     = r_inp;
  assign o_disp    = r_disp;
  assign o_running = (r_state == ST_RUN);
  assign o_full    = w_full;

endmodule

// File: tb/tb_femto_sequencer.sv
// tb_femto_sequencer: scoreboard bench for femto_sequencer with an attached
// accumulator ALU stand-in. The driver steps a program-level reference model
// each cycle and queues the expected outputs; the monitor pops and compares
// one entry per clock edge.
module tb_femto_sequencer;
  import femto_pkg::*;

  localparam int unsigned OPSIZE = 3;
  localparam int unsigned SIZE   = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NIB    = nib_count(SIZE);

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_run;
  logic              i_ld_en;
  logic [3:0]        i_ld_nib;
  logic [SIZE-1:0]   i_alu_out;
  logic [OPSIZE-1:0] o_op;
  logic [SIZE-1:0]   o_inp;
  logic [SIZE-1:0]   o_disp;
  logic              o_running;
  logic              o_full;

  always #5 i_clk = ~i_clk;

  femto_sequencer #(
    .OPSIZE (OPSIZE),
    .SIZE   (SIZE),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (i_run),
    .i_ld_en   (i_ld_en),
    .i_ld_nib  (i_ld_nib),
    .i_alu_out (i_alu_out),
    .o_op      (o_op),
    .o_inp     (o_inp),
    .o_disp    (o_disp),
    .o_running (o_running),
    .o_full    (o_full)
  );

  function automatic logic [SIZE-1:0] alu_next(input logic [SIZE-1:0] acc,
                                               input logic [OPSIZE-1:0] op,
                                               input logic [SIZE-1:0] imm);
    case (int'(op))
      OP_LDI:  return imm;
      OP_ADD:  return acc + imm;
      OP_NOT:  return ~acc;
      OP_AND:  return acc & imm;
      OP_XOR:  return acc ^ imm;
      default: return acc;
    endcase
  endfunction

  // ALU stand-in: output is the accumulator, updated at the edge after issue.
  logic [SIZE-1:0] alu_acc = '0;
  always @(posedge i_clk) alu_acc <= alu_next(alu_acc, o_op, o_inp);
  assign i_alu_out = alu_acc;

  typedef struct packed {
    logic [OPSIZE-1:0] op;
    logic [SIZE-1:0]   inp;
    logic [SIZE-1:0]   disp;
    logic              running;
    logic              full;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  bit   done   = 1'b0;

  // Reference model: the program is a list of words, the partial word a list
  // of nibbles received so far.
  bit                       m_running = 1'b0;
  logic [OPSIZE+SIZE-1:0]   prog[$];
  logic [3:0]               part[$];
  int                       m_pc   = 0;
  logic [OPSIZE-1:0]        m_op   = '0;
  logic [SIZE-1:0]          m_inp  = '0;
  logic [SIZE-1:0]          m_disp = '0;
  logic [SIZE-1:0]          m_acc  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic run, input logic ld_en,
                            input logic [3:0] nib);
    logic [OPSIZE-1:0]      old_op;
    logic [SIZE-1:0]        old_acc;
    logic [SIZE-1:0]        imm;
    logic [3:0]             n0;
    logic [OPSIZE+SIZE-1:0] w;
    old_op  = m_op;
    old_acc = m_acc;
    m_acc   = alu_next(m_acc, m_op, m_inp);
    if (rst) begin
      m_running = 1'b0;
      prog.delete();
      part.delete();
      m_pc   = 0;
      m_op   = '0;
      m_inp  = '0;
      m_disp = '0;
    end else begin
      if (int'(old_op) == OP_STA || int'(old_op) == OP_DISP) m_disp = old_acc;
      if (!m_running) begin
        if (run) begin
          m_running = 1'b1;
          m_pc      = 0;
          part.delete();
        end else if (ld_en && prog.size() < DEPTH) begin
          part.push_back(nib);
          if (part.size() == NIB) begin
            imm = '0;
            for (int k = 1; k < NIB; k++) imm = imm | (SIZE'(part[k]) << (4 * (k - 1)));
            n0 = part[0];
            w  = {n0[OPSIZE-1:0], imm};
            prog.push_back(w);
            part.delete();
          end
        end
      end else begin
        if (!run) begin
          m_running = 1'b0;
          m_op      = '0;
          m_inp     = '0;
          m_pc      = 0;
          prog.delete();
        end else if (prog.size() == 0) begin
          m_op  = '0;
          m_inp = '0;
        end else begin
          w     = prog[m_pc];
          m_op  = w[OPSIZE+SIZE-1:SIZE];
          m_inp = w[SIZE-1:0];
          m_pc  = (m_pc + 1) % prog.size();
        end
      end
    end
  endtask

  // Drive one edge: inputs applied 2 time units after the previous edge.
  task automatic cyc(input logic rst, input logic run, input logic ld_en,
                     input logic [3:0] nib);
    exp_t e;
    i_rst    = rst;
    i_run    = run;
    i_ld_en  = ld_en;
    i_ld_nib = nib;
    model_step(rst, run, ld_en, nib);
    e.op      = m_op;
    e.inp     = m_inp;
    e.disp    = m_disp;
    e.running = m_running;
    e.full    = (prog.size() == DEPTH);
    sb.push_back(e);
    @(posedge i_clk);
    cyc_no++;
    #2;
  endtask

  task automatic lw(input logic [OPSIZE-1:0] op, input logic [SIZE-1:0] imm);
    cyc(1'b0, 1'b0, 1'b1, {1'($urandom % 2), op});
    for (int k = 0; k < NIB - 1; k++) cyc(1'b0, 1'b0, 1'b1, imm[k*4 +: 4]);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (done) break;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d", cyc_no);
      end else begin
        e = sb.pop_front();
        chk("op",      32'(o_op),      32'(e.op));
        chk("inp",     32'(o_inp),     32'(e.inp));
        chk("disp",    32'(o_disp),    32'(e.disp));
        chk("running", 32'(o_running), 32'(e.running));
        chk("full",    32'(o_full),    32'(e.full));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d", cyc_no);
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    logic r_run;
    i_rst = 1'b1; i_run = 1'b0; i_ld_en = 1'b0; i_ld_nib = '0;
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("rst_op", 32'(o_op), 0);
    chk("rst_running", 32'(o_running), 0);
    chk("rst_full", 32'(o_full), 0);

    // LDI 0x15, ADD 0x03, STA
    lw(3'd1, 8'h15); lw(3'd2, 8'h03); lw(3'd6, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("e0_running", 32'(o_running), 1);
    chk("e0_op", 32'(o_op), 0);
    cyc(1'b0, 1'b1, 1'b1, 4'hf);
    chk("e1_op", 32'(o_op), 1); chk("e1_inp", 32'(o_inp), 32'h15);
    cyc(1'b0, 1'b1, 1'b1, 4'h3);
    chk("e2_op", 32'(o_op), 2); chk("e2_inp", 32'(o_inp), 32'h03);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("e3_op", 32'(o_op), 6); chk("e3_inp", 32'(o_inp), 32'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("e4_op", 32'(o_op), 1); chk("e4_inp", 32'(o_inp), 32'h15);
    chk("e4_disp", 32'(o_disp), 32'h18);
    repeat (6) cyc(1'b0, 1'b1, 1'($urandom % 2), 4'($urandom));

    // Reset mid-RUN, then RUN on an empty program
    cyc(1'b1, 1'b1, 1'b0, 4'h0);
    chk("midrst_running", 32'(o_running), 0);
    chk("midrst_disp", 32'(o_disp), 0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("postrst_op", 32'(o_op), 0);
    chk("postrst_running", 32'(o_running), 1);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);

    // Nine words into an eight-word memory
    for (int i = 0; i < 9; i++) begin
      lw(3'($urandom), 8'($urandom));
      if (i == 6) chk("full_after_7", 32'(o_full), 0);
      if (i == 7) chk("full_after_8", 32'(o_full), 1);
    end
    chk("full_after_9", 32'(o_full), 1);
    repeat (20) cyc(1'b0, 1'b1, 1'($urandom % 2), 4'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    chk("drop_full", 32'(o_full), 0);
    chk("drop_op", 32'(o_op), 0);

    // Partial second word discarded
    lw(3'd1, 8'h5a);
    cyc(1'b0, 1'b0, 1'b1, 4'h2);
    cyc(1'b0, 1'b0, 1'b1, 4'h7);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("partial_op", 32'(o_op), 1); chk("partial_inp", 32'(o_inp), 32'h5a);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    lw(3'd5, 8'hc3);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("reload_op", 32'(o_op), 5); chk("reload_inp", 32'(o_inp), 32'hc3);

    // Empty program
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 4'($urandom));
    chk("empty_op", 32'(o_op), 0); chk("empty_running", 32'(o_running), 1);

    // Random traffic
    r_run = 1'b0;
    repeat (400) begin
      if ($urandom % 25 == 0) r_run = ~r_run;
      cyc(($urandom % 120) == 0, r_run, 1'($urandom % 2), 4'($urandom));
    end

    done = 1'b1;
    #10;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/femto_sequencer.md
# femto_sequencer

Program loader and instruction issuer that drives the Femto accumulator ALU's `op`/`inp` port and observes its result output. In LOAD mode it assembles instructions from a 4-bit nibble stream into a small program memory. In RUN mode it replays that program in a loop, one instruction per clock. It captures ALU results into a display register on STORE-ACC/DISPLAY instructions. It sits between the chip's pin-level inputs and the ALU.

## Interface
- `OPSIZE`, 3: opcode width; must be ≤ 4.
- `SIZE`, 8: data/immediate width; must be a multiple of 4.
- `DEPTH`, 8: program memory words; power of two.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `run`  in  1  level: 1 = RUN mode, 0 = LOAD mode.
- `ld_en`  in  1  nibble strobe; sampled only in LOAD.
- `ld_nib`  in  4  nibble data.
- `alu_out`  in  SIZE  ALU combinational result (`outp`).
- `op`  out  OPSIZE  registered opcode to ALU.
- `inp`  out  SIZE  registered operand to ALU.
- `disp`  out  SIZE  registered display value.
- `running`  out  1  state == RUN.
- `full`  out  1  prog_len == DEPTH.

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 NOT, 4 AND, 5 XOR, 6 STA (ALU outputs acc), 7 DISP.
- Word format: {op, imm}, OPSIZE+SIZE bits. NIB = 1 + SIZE/4 nibbles per word.
- Nibble order:
  - nibble 0: op in bits [OPSIZE-1:0]; upper bits ignored.
  - nibbles 1..NIB-1: imm, least-significant nibble first.
- States: LOAD, RUN.
- LOAD:
  - On each `ld_en` edge, the nibble is shifted into the assembly register and `nib_cnt` increments.
  - On the NIB-th nibble: write mem[prog_len], prog_len += 1, `nib_cnt` ← 0.
  - When `full` is set, `ld_en` is ignored entirely and `nib_cnt` does not advance.
  - `op` = 0 and `inp` = 0 in LOAD. The ALU must see an all-zero NOP, because op 0 with inp[3:2] = 01 writes acc.
- LOAD→RUN on an edge with `run` = 1:
  - pc ← 0, `nib_cnt` ← 0; any partial word is discarded.
  - prog_len is kept.
- RUN:
  - Each edge: `op`/`inp` ← mem[pc]; pc ← (pc+1 == prog_len) ? 0 : pc+1.
  - If prog_len = 0, issue NOP (0/0) forever.
  - `ld_en` is ignored.
- RUN→LOAD on an edge with `run` = 0:
  - `op`/`inp` ← 0, pc ← 0, prog_len ← 0, `full` ← 0.
  - A new program overwrites the old one; memory contents need not be cleared.
- Display capture:
  - On any edge where the currently registered `op` is 6 or 7: `disp` ← `alu_out`.
  - Otherwise `disp` holds its value, including across mode changes.
- pc and write pointer are log2(DEPTH) bits; prog_len is log2(DEPTH)+1 bits.

## Timing
- Reset values: `op` 0, `inp` 0, `disp` 0, `running` 0, `full` 0; state LOAD, pc 0, prog_len 0, `nib_cnt` 0.
- `rst` overrides all other inputs in the same edge, including mid-RUN and mid-word.
- Edge E0 samples `run` = 1 in LOAD. At E1, `op`/`inp` show instr 0 and `running` = 1 (`running` is registered with state, so it is already 1 after E0). Instr k is visible after E(1+k), modulo prog_len.
- The ALU updates acc at the edge after issue, so back-to-back instructions see the correct acc.
- `disp` latency: 1 edge after a STA/DISP instruction appears on `op`.
- A load word is written on the edge of its final nibble. `full` is visible after the DEPTH-th write.
- Simultaneous `ld_en` and `run` rising in LOAD: the nibble is discarded and the transition wins.

## Structure
- Shared package `femto_pkg`:
  - opcode constants OP_NOP..OP_DISP;
  - state enum {ST_LOAD, ST_RUN};
  - a helper for the NIB count.
- The ALU should import the same opcode constants.
- Sub-module `femto_prog_mem`: DEPTH × (OPSIZE+SIZE), synchronous write, asynchronous read, no reset.
- Controller, nibble assembler, pc and display register live in `femto_sequencer`.

## Test plan
- Reset: assert `rst` mid-RUN with prog_len 3 → next edge all outputs 0, `running` 0; subsequent RUN issues NOP 0/0.
- Program run (ALU model attached):
  - Load nibbles 1,5,1 / 2,3,0 / 6,0,0; raise `run`.
  - `op`/`inp` sequence must be 1/0x15, 2/0x03, 6/0x00, then wrap to 1/0x15.
  - `disp` = 0x18 one edge after STA issue.
- Full: with DEPTH 8, load 9 words → `full` = 1 after word 8; word 9 ignored. RUN cycles 8 words, pc wraps 7→0.
- Partial word: load 2 nibbles of a second word, then raise `run` → only word 0 issued repeatedly. Drop `run`, load a full word → it lands at address 0.
- Empty program: raise `run` with prog_len 0 → `op` = 0, `inp` = 0 every cycle, `running` = 1, `disp` unchanged.
- Mode drop: drop `run` during instr 1 → next edge NOP, `full` 0; `ld_en` pulses during RUN had no effect.
